// File: rtl/turnstile_example.sv
// turnstile_example: two-state coin/push turnstile; define TURNSTILE_PASS_COUNT_EN to add a wrapping passage counter.
module turnstile_example #(
  parameter int COUNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_coin,
  input  logic               i_push,
  output logic               o_locked
`ifdef TURNSTILE_PASS_COUNT_EN
  ,
  output logic [COUNT_W-1:0] o_pass_count
`endif
);
  typedef enum logic {LOCKED = 1'b0, UNLOCKED = 1'b1} state_e;
  state_e state_q, state_d;
  if (COUNT_W < 1) begin : g_bad_count_w
    $error("COUNT_W must be at least 1");
  end
  always_comb begin
    state_d = state_q;
    if (i_push) state_d = LOCKED;
    else if (i_coin) state_d = UNLOCKED;
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= LOCKED;
    else state_q <= state_d;
  end
  assign o_locked = (state_q == LOCKED);
`ifdef TURNSTILE_PASS_COUNT_EN
  logic [COUNT_W-1:0] pass_count_q, pass_count_d;
  // A passage completes only on the UNLOCKED->LOCKED edge; pushes while locked do not count.
  always_comb pass_count_d = (state_q == UNLOCKED && i_push) ? pass_count_q + 1'b1 : pass_count_q;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) pass_count_q <= '0;
    else pass_count_q <= pass_count_d;
  end
  assign o_pass_count = pass_count_q;
`endif
endmodule

// File: tb/tb_turnstile_example.sv
// tb_turnstile_example: directed plus random check of turnstile_example against a behavioural model.
module tb_turnstile_example;
  localparam int CW = 2;
  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  logic i_coin = 1'b0;
  logic i_push = 1'b0;
  logic o_locked;
  int vectors = 0;
  int miscompares = 0;
  bit m_locked = 1'b1;
  int passes = 0;
`ifdef TURNSTILE_PASS_COUNT_EN
  logic [CW-1:0] o_pass_count;
  turnstile_example #(.COUNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_coin(i_coin), .i_push(i_push),
    .o_locked(o_locked), .o_pass_count(o_pass_count)
  );
`else
  turnstile_example #(.COUNT_W(CW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_coin(i_coin), .i_push(i_push),
    .o_locked(o_locked)
  );
`endif
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, "_locked"}, {31'd0, o_locked}, {31'd0, m_locked});
`ifdef TURNSTILE_PASS_COUNT_EN
    check({tag, "_count"}, {{(32-CW){1'b0}}, o_pass_count}, passes % (1 << CW));
`endif
  endtask
  task automatic step(input string tag, input logic c, input logic p);
    @(negedge i_clk);
    i_coin = c;
    i_push = p;
    @(posedge i_clk);
    if (i_reset_n) begin
      if (p) begin
        if (!m_locked) passes++;
        m_locked = 1'b1;
      end else if (c) m_locked = 1'b0;
    end
    #1;
    check_all(tag);
  endtask
  initial begin
    #1;
    check_all("reset_async");
    repeat (5) step("reset_hold", 1'b0, 1'b0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    repeat (5) step("post_reset", 1'b0, 1'b0);
    repeat (4) step("coin_held", 1'b1, 1'b0);
    repeat (6) step("coin_push", 1'b1, 1'b1);
    step("push_only", 1'b0, 1'b1);
    step("idle", 1'b0, 1'b0);
    repeat (3) step("locked_push", 1'b0, 1'b1);
    step("unlock", 1'b1, 1'b0);
    step("unlocked", 1'b0, 1'b0);
    @(posedge i_clk);
    #2;
    i_reset_n = 1'b0;
    m_locked = 1'b1;
    passes = 0;
    #1;
    check_all("mid_reset");
    step("in_reset", 1'b1, 1'b0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step("wrap_coin", 1'b1, 1'b0);
      step("wrap_push", 1'b0, 1'b1);
    end
    for (int k = 0; k < 300; k++) begin
      step("random", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
